// File: rtl/fpu_fadd_issue_pkg.sv
// Shared FPU definitions for the FP add issue stage: flag layout, exponent
// limits, register-index width and the slot payload types.
package fpu_fadd_issue_pkg;

  localparam int unsigned FP_REG_W    = 4;
  localparam int unsigned FLG_ZERO    = 0;
  localparam int unsigned FLG_INF     = 1;
  localparam int unsigned FLG_SIGN    = 2;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

  typedef struct packed {
    logic                v;
    logic                sub;
    logic [FP_REG_W-1:0] dreg;
    logic [31:0]         a;
    logic [31:0]         b;
  } x_slot_t;

  typedef struct packed {
    logic                v;
    logic [FP_REG_W-1:0] dreg;
    logic [31:0]         data;
    logic [2:0]          flags;
  } r_slot_t;

  // Flags are derived purely from the captured single-precision bit pattern.
  function automatic logic [2:0] fp_flags(input logic [31:0] data);
    logic [2:0] f;
    f           = '0;
    f[FLG_ZERO] = (data[30:0] == 31'd0);
    f[FLG_INF]  = (data[30:23] == FP_EXP_MAX);
    f[FLG_SIGN] = data[31];
    return f;
  endfunction

endpackage

// File: rtl/fpu_fadd_issue_fwd_mux.sv
// Operand forwarding mux for one source: in-flight X result beats the
// R slot, which beats the decode-supplied register-file value.
module fpu_fwd_mux
  import fpu_fadd_issue_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [FP_REG_W-1:0] sreg_i,
  input  logic                x_ok_i,
  input  logic [FP_REG_W-1:0] x_dreg_i,
  input  logic [31:0]         x_data_i,
  input  logic                r_ok_i,
  input  logic [FP_REG_W-1:0] r_dreg_i,
  input  logic [31:0]         r_data_i,
  input  logic [31:0]         fallback_i,
  output logic [31:0]         opnd_o
);

  always_comb begin
    opnd_o = fallback_i;
    if (FWD_EN && x_ok_i && (x_dreg_i == sreg_i)) begin
      opnd_o = x_data_i;
    end else if (FWD_EN && r_ok_i && (r_dreg_i == sreg_i)) begin
      opnd_o = r_data_i;
    end
  end

endmodule

// File: rtl/fpu_fadd_issue.sv
// Issue/forwarding stage for the single-precision FP adder: decode op ->
// X slot (drives the external adder) -> R slot (presented to writeback).
module fpu_fadd_issue
  import fpu_fadd_issue_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic                op_sub,
  input  logic [FP_REG_W-1:0] op_areg,
  input  logic [FP_REG_W-1:0] op_breg,
  input  logic [FP_REG_W-1:0] op_dreg,
  input  logic [31:0]         op_a,
  input  logic [31:0]         op_b,
  input  logic                flush,
  output logic                add_isen,
  output logic                add_dosub,
  output logic [31:0]         add_srca,
  output logic [31:0]         add_srcb,
  input  logic [31:0]         add_dst,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [FP_REG_W-1:0] res_dreg,
  output logic [31:0]         res_data,
  output logic [2:0]          res_flags,
  output logic [1:0]          busy
);

  x_slot_t     x_q, x_d;
  r_slot_t     r_q, r_d;
  logic [1:0]  busy_q, busy_d;
  logic        r_adv, x_adv, accept;
  logic        x_fwd_ok, r_fwd_ok;
  logic [31:0] opnd_a, opnd_b;

  assign r_adv    = !r_q.v || res_ready;
  assign x_adv    = !x_q.v || r_adv;
  assign op_ready = x_adv && !flush;
  assign accept   = op_valid && op_ready;

  // X only ever leaves uncaptured on flush; R's value is stale once it retires,
  // because the register file then already holds it.
  assign x_fwd_ok = x_q.v && !flush;
  assign r_fwd_ok = r_q.v && !res_ready;

  fpu_fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_a (
    .sreg_i     (op_areg),
    .x_ok_i     (x_fwd_ok),
    .x_dreg_i   (x_q.dreg),
    .x_data_i   (add_dst),
    .r_ok_i     (r_fwd_ok),
    .r_dreg_i   (r_q.dreg),
    .r_data_i   (r_q.data),
    .fallback_i (op_a),
    .opnd_o     (opnd_a)
  );

  fpu_fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_b (
    .sreg_i     (op_breg),
    .x_ok_i     (x_fwd_ok),
    .x_dreg_i   (x_q.dreg),
    .x_data_i   (add_dst),
    .r_ok_i     (r_fwd_ok),
    .r_dreg_i   (r_q.dreg),
    .r_data_i   (r_q.data),
    .fallback_i (op_b),
    .opnd_o     (opnd_b)
  );

  always_comb begin
    x_d = x_q;
    if (flush) begin
      x_d.v = 1'b0;
    end else if (accept) begin
      x_d = '{v: 1'b1, sub: op_sub, dreg: op_dreg, a: opnd_a, b: opnd_b};
    end else if (x_adv) begin
      x_d.v = 1'b0;
    end

    r_d = r_q;
    if (flush) begin
      r_d.v = 1'b0;
    end else if (x_q.v && r_adv) begin
      r_d = '{v: 1'b1, dreg: x_q.dreg, data: add_dst, flags: fp_flags(add_dst)};
    end else if (res_ready) begin
      r_d.v = 1'b0;
    end

    busy_d = {1'b0, x_d.v} + {1'b0, r_d.v};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      r_q    <= '0;
      busy_q <= '0;
    end else begin
      x_q    <= x_d;
      r_q    <= r_d;
      busy_q <= busy_d;
    end
  end

  assign add_isen  = x_q.v;
  assign add_dosub = x_q.sub;
  assign add_srca  = x_q.a;
  assign add_srcb  = x_q.b;

  assign res_valid = r_q.v;
  assign res_dreg  = r_q.dreg;
  assign res_data  = r_q.data;
  assign res_flags = r_q.flags;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_fadd_issue.sv
// Bench for fpu_fadd_issue: behavioural FP adder stands in for the real one;
// expectations come from sequential register semantics plus an in-order queue.
module tb_fpu_fadd_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready, op_sub, flush;
  logic [3:0]  op_areg, op_breg, op_dreg;
  logic [31:0] op_a, op_b;
  logic        add_isen, add_dosub;
  logic [31:0] add_srca, add_srcb, add_dst;
  logic        res_valid, res_ready;
  logic [3:0]  res_dreg;
  logic [31:0] res_data;
  logic [2:0]  res_flags;
  logic [1:0]  busy;

  always #5 clk = ~clk;

  fpu_fadd_issue #(.FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_sub(op_sub),
    .op_areg(op_areg), .op_breg(op_breg), .op_dreg(op_dreg),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .add_isen(add_isen), .add_dosub(add_dosub),
    .add_srca(add_srca), .add_srcb(add_srcb), .add_dst(add_dst),
    .res_valid(res_valid), .res_ready(res_ready), .res_dreg(res_dreg),
    .res_data(res_data), .res_flags(res_flags), .busy(busy)
  );

  // Single <-> double conversion; denormals flush to zero, rounding truncates.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'h00)      d = {x[31], 63'b0};
    else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'b0};
    else                        d = {x[31], 11'({3'b0, x[30:23]} + 11'd896), x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 0)        return {d[63], 31'b0};
    if (e == 2047)     return {d[63], 8'hFF, d[51:29]};
    e = e - 896;
    if (e >= 255)      return {d[63], 8'hFF, 23'b0};
    if (e <= 0)        return {d[63], 31'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic sub);
    return r2sp(sub ? sp2r(a) - sp2r(b) : sp2r(a) + sp2r(b));
  endfunction

  function automatic logic [2:0] flags_of(input logic [31:0] v);
    return {v[31], v[30:23] == 8'hFF, v[30:0] == 31'd0};
  endfunction

  always_comb add_dst = fadd(add_srca, add_srcb, add_dosub);

  typedef struct {
    logic [3:0]  d;
    logic [31:0] v;
    int          t;
  } ent_t;

  ent_t        q[$];
  logic [31:0] rf[16];
  logic [31:0] arch[16];
  int          cyc = 0, total = 0, bad = 0, dut_acc = 0;
  logic [31:0] last_data;
  logic [2:0]  last_flags;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic wb_pending();
    return q.size() > 0 && (cyc - q[0].t) >= 2 && res_ready;
  endfunction

  // Decode's register read; the register file writes through same-cycle.
  function automatic logic [31:0] rd(input logic [3:0] r);
    if (wb_pending() && q[0].d == r) return q[0].v;
    return rf[r];
  endfunction

  task automatic step();
    logic ordy, rv, wb, acc;
    ent_t e;
    #1;
    rv   = q.size() > 0 && (cyc - q[0].t) >= 2;
    ordy = (q.size() < 2 || res_ready) && !flush;
    chk("op_ready", 32'(op_ready), 32'(ordy));
    chk("res_valid", 32'(res_valid), 32'(rv));
    chk("busy", 32'(busy), 32'(q.size()));
    wb = rv && res_ready;
    if (wb) begin
      chk("res_dreg", 32'(res_dreg), 32'(q[0].d));
      chk("res_data", res_data, q[0].v);
      chk("res_flags", 32'(res_flags), 32'(flags_of(q[0].v)));
      last_data  = res_data;
      last_flags = res_flags;
    end
    if (op_valid && op_ready) dut_acc++;
    acc = op_valid && ordy;
    @(posedge clk);
    if (wb) begin
      rf[q[0].d] = q[0].v;
      void'(q.pop_front());
    end
    if (acc) begin
      e.d = op_dreg;
      e.v = fadd(arch[op_areg], arch[op_breg], op_sub);
      e.t = cyc;
      arch[op_dreg] = e.v;
      q.push_back(e);
    end
    if (flush) begin
      q.delete();
      arch = rf;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic sub, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    op_valid = 1'b1;
    op_sub   = sub;
    op_areg  = a;
    op_breg  = b;
    op_dreg  = d;
    op_a     = rd(a);
    op_b     = rd(b);
  endtask

  task automatic idle();
    op_valid = 1'b0;
    step();
  endtask

  task automatic drain();
    int n;
    op_valid  = 1'b0;
    flush     = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 30) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $error("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, res_data, 32'd0);
    chk({tag, "_res_dreg"}, 32'(res_dreg), 32'd0);
    chk({tag, "_res_flags"}, 32'(res_flags), 32'd0);
    chk({tag, "_add_isen"}, 32'(add_isen), 32'd0);
    chk({tag, "_add_dosub"}, 32'(add_dosub), 32'd0);
    chk({tag, "_add_srca"}, add_srca, 32'd0);
    chk({tag, "_add_srcb"}, add_srcb, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic set_reg(input logic [3:0] r, input logic [31:0] v);
    rf[r]   = v;
    arch[r] = v;
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op_sub = 1'b0; flush = 1'b0; res_ready = 1'b1;
    op_areg = '0; op_breg = '0; op_dreg = '0; op_a = '0; op_b = '0;
    for (int i = 0; i < 16; i++) begin rf[i] = '0; arch[i] = '0; end
    #1;
    check_rst("por");
    @(negedge clk);
    reset = 1'b1;

    // 1.0 + 2.0
    set_reg(4'd1, 32'h3F800000);
    set_reg(4'd3, 32'h40000000);
    drive(1'b0, 4'd1, 4'd3, 4'd4);
    step();
    drain();
    chk("sum_1p2", last_data, 32'h40400000);
    chk("flags_1p2", 32'(last_flags), 32'd0);

    // 1.0 - 1.0 -> zero flag
    drive(1'b1, 4'd1, 4'd1, 4'd5);
    step();
    drain();
    chk("sub_zero", last_data, 32'h00000000);
    chk("flags_zero", 32'(last_flags), 32'b001);

    // overflow to infinity
    set_reg(4'd6, 32'h7F000000);
    drive(1'b0, 4'd6, 4'd6, 4'd7);
    step();
    drain();
    chk("sum_inf", last_data, 32'h7F800000);
    chk("flags_inf", 32'(last_flags), 32'b010);

    // RAW back-to-back: forward from X
    set_reg(4'd2, 32'h0);
    drive(1'b0, 4'd1, 4'd1, 4'd2);
    step();
    drive(1'b0, 4'd2, 4'd1, 4'd8);
    chk("raw_x_stale", op_a, 32'h0);
    step();
    drain();
    chk("raw_x_fwd", last_data, 32'h40400000);

    // RAW with one bubble: producer parked in R
    set_reg(4'd2, 32'h0);
    drive(1'b0, 4'd1, 4'd1, 4'd2);
    step();
    idle();
    res_ready = 1'b0;
    drive(1'b0, 4'd2, 4'd1, 4'd9);
    step();
    drain();
    chk("raw_r_fwd", last_data, 32'h40400000);

    // Backpressure: 4 cycles of res_ready=0 with continuous requests
    res_ready = 1'b0;
    dut_acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd1, 4'(10 + i), 4'(10 + i));
      step();
    end
    chk("bp_accepts", 32'(dut_acc), 32'd2);
    chk("bp_busy", 32'(busy), 32'd2);
    chk("bp_op_ready", 32'(op_ready), 32'd0);
    drain();

    // Flush with both slots full
    res_ready = 1'b0;
    drive(1'b0, 4'd1, 4'd1, 4'd11);
    step();
    drive(1'b0, 4'd11, 4'd1, 4'd12);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    op_valid = 1'b0;
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    step();

    // Async reset with X and R full
    res_ready = 1'b0;
    drive(1'b1, 4'd3, 4'd1, 4'd13);
    step();
    drive(1'b0, 4'd13, 4'd3, 4'd14);
    step();
    op_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_rst("mid");
    q.delete();
    arch = rf;
    @(negedge clk);
    reset = 1'b1;
    res_ready = 1'b1;
    drive(1'b0, 4'd1, 4'd3, 4'd15);
    step();
    drain();
    chk("post_rst", last_data, 32'h40400000);

    // Randomized traffic with tight register reuse
    for (int i = 0; i < 4; i++)
      set_reg(4'(i), {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 15)), 23'($urandom)});
    for (int i = 0; i < 400; i++) begin
      flush     = ($urandom_range(0, 49) == 0);
      res_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)));
      else
        op_valid = 1'b0;
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
